fsm_mc: RTL

FSM_MC -- requirements
Module: fsm_mc

---
 rtl/fsm_mc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fsm_mc.sv
// rtl/fsm_mc.sv - multicycle RV32I control FSM with memory wait timeout.
// Optional feature macro: CTRL_TRAP_EN (illegal opcodes go through a one-cycle TRAP state).
package fsm_mc_pkg;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, EXEC_R, EXEC_I, MEM_READ,
        MEM_WRITE, MEM_WB, ALU_WB, BRANCH, JUMP, TRAP
    } state_t;
    typedef enum logic       {ADDR_PC, ADDR_RESULT}          mem_addr_sel_t;
    typedef enum logic [1:0] {RS1V, PC, PC_OLD}              alu_src1_sel_t;
    typedef enum logic [1:0] {RS2V, IMM, PC_INC}             alu_src2_sel_t;
    typedef enum logic [1:0] {ALU_CLOCKED, ALU_RESULT, MEM_RD} result_sel_t;
    typedef enum logic [1:0] {ADD_OP, SUB_OP, FUNCT_DEFINED} alu_ops_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

module fsm_mc
    import fsm_mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_update,
    output logic             inst_en,
    output logic             reg_wren,
    output logic             mem_wren,
    output logic             branch,
    output logic [2:0]       branch_funct3,
    output mem_addr_sel_t    mem_addr_sel,
    output alu_src1_sel_t    alu_src1_sel,
    output alu_src2_sel_t    alu_src2_sel,
    output result_sel_t      result_sel,
    output alu_ops_t         alu_op,
    output logic             bus_err,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t          r_state, w_next;
    logic [15:0]     r_wait;
    logic            r_mem_req, r_inst_en, r_reg_wren, r_mem_wren, r_branch, r_bus_err;
    logic [2:0]      r_branch_funct3;
    mem_addr_sel_t   r_mem_addr_sel, w_mem_addr_sel;
    alu_src1_sel_t   r_src1, w_src1;
    alu_src2_sel_t   r_src2, w_src2;
    result_sel_t     r_result_sel, w_result_sel;
    alu_ops_t        r_alu_op, w_alu_op;
    logic [CNT_W-1:0] r_instret;
    logic            w_in_mem, w_timeout, w_retire;

    always_comb begin
        w_in_mem  = (r_state == FETCH) || (r_state == MEM_READ) || (r_state == MEM_WRITE);
        w_timeout = w_in_mem && !mem_ready && (r_wait == TO_LAST);
        w_retire  = (r_state == MEM_WB) || (r_state == ALU_WB) || (r_state == BRANCH)
                    || ((r_state == MEM_WRITE) && mem_ready);
        w_next    = r_state;
        case (r_state)
            IDLE:     w_next = FETCH;
            FETCH:    if (mem_ready) w_next = DECODE;
            DECODE: begin
                case (opcode)
                    OPC_R:                        w_next = EXEC_R;
                    OPC_I, OPC_LUI, OPC_AUIPC:    w_next = EXEC_I;
                    OPC_LOAD, OPC_STORE:          w_next = MEM_ADDR;
                    OPC_BRANCH:                   w_next = BRANCH;
                    OPC_JAL, OPC_JALR:            w_next = JUMP;
`ifdef CTRL_TRAP_EN
                    default:                      w_next = TRAP;
`else
                    default:                      w_next = FETCH;
`endif
                endcase
            end
            MEM_ADDR: w_next = (opcode == OPC_STORE) ? MEM_WRITE : MEM_READ;
            EXEC_R, EXEC_I, JUMP: w_next = ALU_WB;
            MEM_READ: begin
                if (mem_ready)      w_next = MEM_WB;
                else if (w_timeout) w_next = FETCH;
            end
            MEM_WRITE: if (mem_ready || w_timeout) w_next = FETCH;
            default:  w_next = FETCH;
        endcase
    end

    // Selects are decoded from the next state so they are valid the cycle the state becomes current.
    always_comb begin
        w_mem_addr_sel = ADDR_PC;
        w_src1         = RS1V;
        w_src2         = RS2V;
        w_alu_op       = ADD_OP;
        w_result_sel   = ALU_CLOCKED;
        case (w_next)
            FETCH:    begin w_src1 = PC; w_src2 = PC_INC; w_result_sel = ALU_RESULT; end
            DECODE:   begin w_src1 = (opcode == OPC_JALR) ? RS1V : PC_OLD; w_src2 = IMM; end
            MEM_ADDR: w_src2 = IMM;
            EXEC_R:   w_alu_op = FUNCT_DEFINED;
            EXEC_I:   begin w_src2 = IMM; w_alu_op = FUNCT_DEFINED; end
            MEM_READ, MEM_WRITE: w_mem_addr_sel = ADDR_RESULT;
            MEM_WB:   w_result_sel = MEM_RD;
            BRANCH:   w_alu_op = SUB_OP;
            JUMP:     begin w_src1 = PC_OLD; w_src2 = PC_INC; end
            default:  w_src1 = RS1V;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_wait          <= '0;
            r_mem_req       <= 1'b0;
            r_inst_en       <= 1'b0;
            r_reg_wren      <= 1'b0;
            r_mem_wren      <= 1'b0;
            r_branch        <= 1'b0;
            r_bus_err       <= 1'b0;
            r_branch_funct3 <= '0;
            r_mem_addr_sel  <= ADDR_PC;
            r_src1          <= RS1V;
            r_src2          <= RS2V;
            r_result_sel    <= ALU_CLOCKED;
            r_alu_op        <= ADD_OP;
            r_instret       <= '0;
        end else begin
            r_state        <= w_next;
            r_wait         <= (w_in_mem && !mem_ready && !w_timeout) ? r_wait + 16'd1 : '0;
            r_mem_req      <= (w_next == FETCH) || (w_next == MEM_READ) || (w_next == MEM_WRITE);
            r_inst_en      <= (w_next == FETCH);
            r_reg_wren     <= (w_next == MEM_WB) || (w_next == ALU_WB);
            r_mem_wren     <= (w_next == MEM_WRITE);
            r_branch       <= (w_next == BRANCH);
            r_bus_err      <= w_timeout;
            r_mem_addr_sel <= w_mem_addr_sel;
            r_src1         <= w_src1;
            r_src2         <= w_src2;
            r_result_sel   <= w_result_sel;
            r_alu_op       <= w_alu_op;
            if (r_state == DECODE) r_branch_funct3 <= funct3;
            if (w_retire)          r_instret <= r_instret + CNT_W'(1);
        end
    end

`ifdef CTRL_TRAP_EN
    logic r_trap;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_trap <= 1'b0;
        else        r_trap <= (w_next == TRAP);
    end
    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

    // PC strobe follows mem_ready combinationally so a stalled fetch updates the PC exactly once.
    assign pc_update     = ((r_state == FETCH) && mem_ready) || (r_state == JUMP);
    assign mem_req       = r_mem_req;
    assign inst_en       = r_inst_en;
    assign reg_wren      = r_reg_wren;
    assign mem_wren      = r_mem_wren;
    assign branch        = r_branch;
    assign branch_funct3 = r_branch_funct3;
    assign mem_addr_sel  = r_mem_addr_sel;
    assign alu_src1_sel  = r_src1;
    assign alu_src2_sel  = r_src2;
    assign result_sel    = r_result_sel;
    assign alu_op        = r_alu_op;
    assign bus_err       = r_bus_err;
    assign instret       = r_instret;
endmodule
